// File: rtl/mii_rx_framer.sv
// MII receive framer: finds preamble/SFD, assembles bytes LSN first, checks CRC-32
// and length, and reports each frame with a one-cycle end-of-frame strobe and status.
module mii_rx_framer (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        MII_RX_CLK,
  input  logic        MII_RX_EN,
  input  logic [3:0]  MII_RXD,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [10:0] rx_len,
  output logic [3:0]  rx_stat,
  output logic        rx_good
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_PRESET  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] GIANT_LAST  = 11'd1518;

  state_t      state_r, state_s;
  logic        rx_clk_r;
  logic        tick_s;
  logic        phase_r;
  logic [3:0]  low_nib_r;
  logic [10:0] count_r;
  logic [10:0] count_next_s;
  logic [31:0] crc_r;
  logic [31:0] crc_next_s;
  logic [7:0]  byte_s;
  logic [3:0]  stat_s;
  logic        sfd_s;
  logic        byte_done_s;
  logic        frame_end_s;
  logic        giant_s;

  // Reflected CRC-32 update of one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Sample point is the clk_in cycle just after MII_RX_CLK falls (mid-nibble).
  assign tick_s       = rx_clk_r & ~MII_RX_CLK;
  assign byte_s       = {MII_RXD, low_nib_r};
  assign crc_next_s   = crc32_byte(crc_r, byte_s);
  assign count_next_s = (count_r == 11'd2047) ? count_r : count_r + 11'd1;
  assign stat_s       = {phase_r, 1'b0, (count_r < 11'd64), (crc_r != CRC_RESIDUE)};

  // Next-state logic and per-tick events.
  always_comb begin
    state_s     = state_r;
    sfd_s       = 1'b0;
    byte_done_s = 1'b0;
    frame_end_s = 1'b0;
    giant_s     = 1'b0;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (!MII_RX_EN) begin
            state_s = IDLE;
          end else if (MII_RXD == 4'h5) begin
            state_s = PREAMBLE;
          end else begin
            state_s = DROP;
          end
        end
        PREAMBLE: begin
          if (!MII_RX_EN) begin
            state_s = IDLE;
          end else if (MII_RXD == 4'h5) begin
            state_s = PREAMBLE;
          end else if (MII_RXD == 4'hD) begin
            state_s = DATA;
            sfd_s   = 1'b1;
          end else begin
            state_s = DROP;
          end
        end
        DATA: begin
          if (!MII_RX_EN) begin
            frame_end_s = 1'b1;
            state_s     = IDLE;
          end else if (phase_r) begin
            byte_done_s = 1'b1;
            if (count_r == GIANT_LAST) begin
              giant_s = 1'b1;
              state_s = DROP;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = DATA;
          end
        end
        DROP: begin
          if (!MII_RX_EN) begin
            state_s = IDLE;
          end else begin
            state_s = DROP;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Edge detector, nibble pairing, byte counter and CRC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_clk_r  <= 1'b0;
      phase_r   <= 1'b0;
      low_nib_r <= 4'h0;
      count_r   <= 11'd0;
      crc_r     <= 32'h0000_0000;
    end else begin
      rx_clk_r <= MII_RX_CLK;
      if (sfd_s) begin
        phase_r <= 1'b0;
        count_r <= 11'd0;
        crc_r   <= CRC_PRESET;
      end else if (tick_s && (state_r == DATA) && MII_RX_EN) begin
        if (phase_r) begin
          phase_r <= 1'b0;
          count_r <= count_next_s;
          crc_r   <= crc_next_s;
        end else begin
          phase_r   <= 1'b1;
          low_nib_r <= MII_RXD;
        end
      end
    end
  end

  // Registered outputs: strobes last one cycle, data/len/stat hold until replaced.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_len   <= 11'd0;
      rx_stat  <= 4'h0;
      rx_good  <= 1'b0;
    end else begin
      rx_valid <= byte_done_s;
      rx_sof   <= byte_done_s && (count_r == 11'd0);
      rx_eof   <= frame_end_s | giant_s;
      rx_good  <= frame_end_s && (stat_s == 4'h0);
      if (byte_done_s) begin
        rx_data <= byte_s;
      end
      if (giant_s) begin
        rx_len  <= count_next_s;
        rx_stat <= 4'b0100;
      end else if (frame_end_s) begin
        rx_len  <= count_r;
        rx_stat <= stat_s;
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: expected bytes and end-of-frame records are queued
// as nibbles are driven and compared by a monitor when the framer strobes them out.
module tb_mii_rx_framer;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        MII_RX_CLK = 1'b0;
  logic        MII_RX_EN = 1'b0;
  logic [3:0]  MII_RXD = 4'h0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] rx_len;
  logic [3:0]  rx_stat;
  logic        rx_good;

  typedef struct {
    logic [10:0] len;
    logic [3:0]  stat;
    logic        good;
    logic        giant;
  } eof_t;

  logic [8:0]  byte_q[$];
  eof_t        eof_q[$];
  logic [7:0]  frame_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [10:0] last_len = 11'd0;

  mii_rx_framer dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .MII_RX_CLK(MII_RX_CLK),
    .MII_RX_EN(MII_RX_EN),
    .MII_RXD(MII_RXD),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_sof(rx_sof),
    .rx_eof(rx_eof),
    .rx_len(rx_len),
    .rx_stat(rx_stat),
    .rx_good(rx_good)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MII clock runs at clk_in/4; one nibble per MII clock period.
  task automatic nib(input logic en, input logic [3:0] d);
    @(negedge clk_in);
    MII_RX_EN  = en;
    MII_RXD    = d;
    MII_RX_CLK = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    MII_RX_CLK = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic make_frame(input int n_total);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 0; i < n_total - 4; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'h0, frame_q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
  endtask

  task automatic preamble(input logic bad);
    for (int i = 0; i < 15; i++) nib(1'b1, (bad && i == 4) ? 4'h3 : 4'h5);
    nib(1'b1, 4'hD);
  endtask

  task automatic drain();
    int n = 0;
    while ((byte_q.size() != 0 || eof_q.size() != 0) && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check("bytes_drained", byte_q.size(), 0);
    check("eof_drained", eof_q.size(), 0);
    check("rx_len_hold", rx_len, last_len);
    byte_q.delete();
    eof_q.delete();
  endtask

  task automatic send_frame(input logic bad_pre, input logic extra,
                            input logic [3:0] exp_stat, input logic expect_out);
    eof_t e;
    preamble(bad_pre);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (expect_out && i < 1519) begin
        byte_q.push_back({(i == 0), frame_q[i]});
        if (i == 1518) begin
          e.len = 11'd1519; e.stat = 4'b0100; e.good = 1'b0; e.giant = 1'b1;
          eof_q.push_back(e);
          last_len = 11'd1519;
        end
      end
      nib(1'b1, frame_q[i][3:0]);
      nib(1'b1, frame_q[i][7:4]);
    end
    if (extra) nib(1'b1, 4'hA);
    if (expect_out && frame_q.size() < 1519) begin
      e.len = 11'(frame_q.size()); e.stat = exp_stat; e.good = (exp_stat == 4'h0); e.giant = 1'b0;
      eof_q.push_back(e);
      last_len = e.len;
    end
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h0);
    drain();
  endtask

  // Scoreboard: pop and compare whenever a strobe appears.
  always @(negedge clk_in) begin
    logic [8:0] b;
    eof_t e;
    if (rx_valid) begin
      check("byte_expected", (byte_q.size() > 0), 1);
      if (byte_q.size() > 0) begin
        b = byte_q.pop_front();
        check("rx_data", rx_data, b[7:0]);
        check("rx_sof", rx_sof, b[8]);
      end
    end
    if (rx_eof) begin
      check("eof_expected", (eof_q.size() > 0), 1);
      if (eof_q.size() > 0) begin
        e = eof_q.pop_front();
        check("rx_len", rx_len, e.len);
        check("rx_stat", rx_stat, e.stat);
        check("rx_good", rx_good, e.good);
        check("valid_with_eof", rx_valid, e.giant);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_sof", rx_sof, 1'b0);
    check("rst_rx_eof", rx_eof, 1'b0);
    check("rst_rx_len", rx_len, 11'd0);
    check("rst_rx_stat", rx_stat, 4'h0);
    check("rst_rx_good", rx_good, 1'b0);
    rst_n_in = 1'b1;
    repeat (2) nib(1'b0, 4'h0);

    make_frame(64);
    send_frame(1'b0, 1'b0, 4'b0000, 1'b1);

    make_frame(64);
    frame_q[10] = frame_q[10] ^ 8'h04;
    send_frame(1'b0, 1'b0, 4'b0001, 1'b1);

    make_frame(60);
    send_frame(1'b0, 1'b0, 4'b0010, 1'b1);

    make_frame(64);
    send_frame(1'b0, 1'b1, 4'b1000, 1'b1);

    frame_q.delete();
    for (int i = 0; i < 1600; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    send_frame(1'b0, 1'b0, 4'b0100, 1'b1);

    make_frame(64);
    send_frame(1'b1, 1'b0, 4'b0000, 1'b0);
    make_frame(64);
    send_frame(1'b0, 1'b0, 4'b0000, 1'b1);

    make_frame(64);
    preamble(1'b0);
    for (int i = 0; i < 10; i++) begin
      byte_q.push_back({(i == 0), frame_q[i]});
      nib(1'b1, frame_q[i][3:0]);
      nib(1'b1, frame_q[i][7:4]);
    end
    @(negedge clk_in);
    check("bytes_before_reset", byte_q.size(), 0);
    rst_n_in = 1'b0;
    #1;
    check("midrst_rx_len", rx_len, 11'd0);
    check("midrst_rx_stat", rx_stat, 4'h0);
    check("midrst_rx_data", rx_data, 8'h00);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    last_len = 11'd0;
    for (int i = 0; i < 20; i++) begin
      nib(1'b1, 4'h0);
      nib(1'b1, 4'h0);
    end
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h0);
    drain();
    make_frame(64);
    send_frame(1'b0, 1'b0, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mii_rx_framer.md
MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have port clk_in  input  1  80 MHz system clock; the same clock that drives the PHY receive stage.
REQ-002 SHALL have port rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port MII_RX_CLK  input  1  2.5 MHz MII receive clock, generated synchronously to clk_in.
REQ-004 SHALL have port MII_RX_EN  input  1  MII receive enable.
REQ-005 SHALL have port MII_RXD  input  4  MII receive nibble, least-significant nibble first.
REQ-006 SHALL have port rx_data  output  8  received byte, FCS included.
REQ-007 SHALL have port rx_valid  output  1  one-cycle strobe marking rx_data valid.
REQ-008 SHALL have port rx_sof  output  1  asserted with rx_valid on the first byte after the SFD.
REQ-009 SHALL have port rx_eof  output  1  one-cycle end-of-frame strobe.
REQ-010 SHALL have port rx_len  output  11  byte count including FCS; valid while rx_eof=1.
REQ-011 SHALL have port rx_stat  output  4  {align, giant, runt, crc_err}; valid while rx_eof=1.
REQ-012 SHALL have port rx_good  output  1  rx_eof=1 and rx_stat=0.

Function
REQ-013 SHALL register MII_RX_CLK once and define a sample tick as the clk_in cycle where the previous value is 1 and the current value is 0 (mid-nibble).
REQ-014 SHALL capture MII_RX_EN and MII_RXD only on sample ticks; all state changes below occur only on ticks, except strobe clearing.
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: EN=1 with nibble 0x5 -> PREAMBLE; EN=1 with any other nibble -> DROP; EN=0 -> stay.
REQ-017 PREAMBLE: EN=1 with nibble 0x5 -> stay; EN=1 with 0xD -> DATA; EN=1 with any other nibble -> DROP; EN=0 -> IDLE with no strobe.
REQ-018 DATA: the even nibble is held as the low half; the odd nibble completes the byte {odd, even}. rx_valid SHALL pulse for exactly 1 clk_in cycle, in the cycle after the completing tick.
REQ-019 DATA: EN=0 -> rx_eof pulses 1 cycle after that tick, and the state goes to IDLE.
REQ-020 DROP: produces no strobes; EN=0 -> IDLE.
REQ-021 SHALL keep an 11-bit byte counter, cleared on SFD and incremented per byte; it saturates at 2047.
REQ-022 SHALL compute CRC-32 in reflected form: polynomial 0xEDB88320, LSB first, preset 0xFFFFFFFF on SFD, updated per byte across data and FCS.
REQ-023 crc_err SHALL be set when the final CRC register is not 0xDEBB20E3.
REQ-024 runt SHALL be set when rx_len < 64.
REQ-025 align SHALL be set when the frame ends with an unpaired nibble; the dangling nibble is discarded.
REQ-026 giant: on byte 1519, SHALL output that byte, pulse rx_eof in the same cycle with giant=1, and enter DROP; the remaining frame produces nothing.
REQ-027 rx_len and rx_stat SHALL hold their values until the next rx_eof; rx_data SHALL hold until the next rx_valid.
REQ-028 Within a frame, rx_valid and rx_eof SHALL never coincide, except in the giant case.
REQ-029 SHALL emit exactly one rx_eof per accepted SFD.

Reset
REQ-030 rst_n_in=0 SHALL immediately force IDLE and clear all outputs, counters, the CRC register, and the edge register; rx_data, rx_len, and rx_stat reset to 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no rx_eof; after release, the block SHALL wait for a fresh EN=0 -> preamble sequence (entering DROP if EN=1 with a non-0x5 nibble).

Verification
REQ-032 7x 0x55 + 0xD5 followed by a valid 64-byte frame with correct FCS -> 64 rx_valid pulses, first with rx_sof, then rx_eof with rx_len=64, rx_stat=0, rx_good=1.
REQ-033 Same frame with one data bit flipped -> rx_eof with rx_stat=0001, rx_good=0.
REQ-034 Valid 60-byte frame (with correct FCS) -> rx_len=60, rx_stat=0010.
REQ-035 64-byte frame plus one extra nibble before EN drops -> rx_len=64, rx_stat=1000.
REQ-036 1600-byte burst -> 1519 rx_valid pulses, a single rx_eof with rx_stat=0100 coinciding with byte 1519, then silence until EN=0.
REQ-037 Preamble containing nibble 0x3 before the SFD, or rst_n_in pulsed low mid-frame -> no rx_valid or rx_eof for that frame; the next clean frame is received with rx_good=1.
